// File: rtl/lcd_text_writer.sv
// -----------------------------------------------------------------------------
// lcd_text_writer
//   Producer side of the LCD text path. Consumes an ASCII byte stream
//   (valid/ready), tracks a text cursor and writes cell codes into the
//   write port of the character RAM that the LCD scan engine reads.
//   Control codes handled: CR, LF, BS, FF. Printable bytes are written at
//   the cursor; bytes 0x7F..0xFF are shown as '?'. Writing the last column
//   wraps to the next row, and moving to a new row blanks that row first.
//   The row after the last one is row 0.
//
// Ports
//   CLK_PIX     in   pixel clock (only clock)
//   RST         in   synchronous active-high reset
//   in_data     in   [7:0] ASCII byte
//   in_valid    in   in_data valid
//   in_ready    out  byte accepted when in_valid & in_ready
//   wr_en       out  text RAM write strobe
//   wr_addr     out  [ADDR_W-1:0] cell address = row*COLS + col
//   wr_data     out  [7:0] cell code
//   cursor_col  out  [5:0] current column
//   cursor_row  out  [4:0] current row
//   busy        out  a screen or row clear is in progress
// -----------------------------------------------------------------------------
module lcd_text_writer #(
  parameter int COLS   = 60,
  parameter int ROWS   = 17,
  parameter int ADDR_W = 10
) (
  input  logic              CLK_PIX,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR_ALL,
    ST_CLEAR_ROW
  } state_t;

  localparam logic [ADDR_W-1:0] L_COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] L_LAST_CELL   = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] L_LAST_IN_ROW = ADDR_W'(COLS - 1);
  localparam logic [5:0]        L_LAST_COL    = 6'(COLS - 1);
  localparam logic [4:0]        L_LAST_ROW    = 5'(ROWS - 1);
  localparam logic [7:0]        L_SPACE       = 8'h20;
  localparam logic [7:0]        L_QMARK       = 8'h3F;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;       // clear progress counter
  logic [ADDR_W-1:0] r_base;      // row*COLS, kept incrementally
  logic [5:0]        r_col;
  logic [4:0]        r_row;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic [4:0]        w_next_row;
  logic [ADDR_W-1:0] w_next_base;
  logic [ADDR_W-1:0] w_cursor_addr;
  logic [7:0]        w_glyph;

  // r_in_ready is only ever high in IDLE, so it alone qualifies a transfer.
  assign w_accept      = in_valid & r_in_ready;
  assign w_last_col    = (r_col == L_LAST_COL);
  assign w_last_row    = (r_row == L_LAST_ROW);
  assign w_next_row    = w_last_row ? 5'd0 : r_row + 5'd1;
  assign w_next_base   = w_last_row ? '0 : r_base + L_COLS_A;
  assign w_cursor_addr = r_base + ADDR_W'(r_col);
  assign w_glyph       = (in_data >= 8'h7F) ? L_QMARK : in_data;

  // in_ready/busy are registered from the next state, so they describe the
  // state the FSM is in during the following cycle.
  always_ff @(posedge CLK_PIX) begin
    if (RST) begin
      r_state    <= ST_CLEAR_ALL;
      r_idx      <= '0;
      r_base     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= L_SPACE;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_CLEAR_ALL: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_idx;
          r_wr_data <= L_SPACE;
          if (r_idx == L_LAST_CELL) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_CLEAR_ROW: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_base + r_idx;
          r_wr_data <= L_SPACE;
          if (r_idx == L_LAST_IN_ROW) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_IDLE: begin
          if (w_accept) begin
            if (in_data == 8'h0C) begin
              // Form feed: home the cursor and blank the whole screen.
              r_col      <= '0;
              r_row      <= '0;
              r_base     <= '0;
              r_idx      <= '0;
              r_state    <= ST_CLEAR_ALL;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else if (in_data == 8'h0D) begin
              r_col <= '0;
            end else if (in_data == 8'h0A) begin
              // Line feed: the first blanking write of the new row goes out
              // right away, the remaining COLS-1 follow in CLEAR_ROW.
              r_row      <= w_next_row;
              r_base     <= w_next_base;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= w_next_base;
              r_wr_data  <= L_SPACE;
              r_idx      <= ADDR_W'(1);
              r_state    <= ST_CLEAR_ROW;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else if (in_data == 8'h08) begin
              if (r_col != 6'd0) begin
                r_col     <= r_col - 6'd1;
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_cursor_addr - 1'b1;
                r_wr_data <= L_SPACE;
              end
            end else if (in_data >= 8'h20) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_cursor_addr;
              r_wr_data <= w_glyph;
              if (w_last_col) begin
                // Wrap: character lands this cycle, row blanking follows.
                r_col      <= '0;
                r_row      <= w_next_row;
                r_base     <= w_next_base;
                r_idx      <= '0;
                r_state    <= ST_CLEAR_ROW;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
              end else begin
                r_col <= r_col + 6'd1;
              end
            end
            // Remaining control codes are consumed without effect.
          end
        end

        default: begin
          r_state    <= ST_CLEAR_ALL;
          r_idx      <= '0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_lcd_text_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_writer
//   Directed bench for lcd_text_writer: reset and full-screen clear, text
//   writes, wrap with row clear, LF on the last row, CR/BS/ignored codes,
//   high-byte substitution, reset during a form-feed clear, and a mixed
//   byte stream compared cell by cell against a reference console model.
// -----------------------------------------------------------------------------
module tb_lcd_text_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  always #5 clk = ~clk;

  lcd_text_writer #(.COLS(60), .ROWS(17), .ADDR_W(10)) dut (
    .CLK_PIX    (clk),
    .RST        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Image of the text RAM built from the DUT write port, plus a write log.
  logic [7:0] dut_ram [0:1023];
  logic [9:0] q_addr [$];
  logic [7:0] q_data [$];
  int         wr_count = 0;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      dut_ram[wr_addr] = wr_data;
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      wr_count++;
    end
  end

  // Reference console: screen contents and cursor.
  logic [7:0] exp_ram [0:1019];
  int m_row = 0;
  int m_col = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    wr_count = 0;
  endtask

  task automatic m_clear_all();
    for (int i = 0; i < 1020; i++) exp_ram[i] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic m_advance();
    m_row = (m_row == 16) ? 0 : m_row + 1;
    for (int i = 0; i < 60; i++) exp_ram[m_row * 60 + i] = 8'h20;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0C) begin
      m_clear_all();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_advance();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_ram[m_row * 60 + m_col] = 8'h20;
      end
    end else if (b >= 8'h20) begin
      exp_ram[m_row * 60 + m_col] = (b >= 8'h7F) ? 8'h3F : b;
      if (m_col == 59) begin
        m_col = 0;
        m_advance();
      end else begin
        m_col++;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge just after the transfer,
  // where the write produced by the byte (if any) is on the port.
  task automatic send(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_handshake", 32'(n < 3000), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    model_byte(b);
    $display("tx byte=%02h wr_en=%0d addr=%0d data=%02h col=%0d row=%0d",
             b, wr_en, wr_addr, wr_data, cursor_col, cursor_row);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(in_ready === 1'b1 && wr_en === 1'b0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 4000), 32'd1);
  endtask

  task automatic check_clear_all(input string tag);
    int ok;
    ok = 1;
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] !== 10'(i) || q_data[i] !== 8'h20) ok = 0;
    check({tag, "_count"}, 32'(q_addr.size()), 32'd1020);
    check({tag, "_seq"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    int ok;
    int mism;
    int r;
    logic [7:0] b;

    // ---------------- reset values ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en",    32'(wr_en),      32'd0);
    check("rst_wr_addr",  32'(wr_addr),    32'd0);
    check("rst_wr_data",  32'(wr_data),    32'h20);
    check("rst_col",      32'(cursor_col), 32'd0);
    check("rst_row",      32'(cursor_row), 32'd0);
    check("rst_in_ready", 32'(in_ready),   32'd0);
    check("rst_busy",     32'(busy),       32'd1);

    // ---------------- T1: power-up clear ----------------
    clear_log();
    m_clear_all();
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_wr_en", 32'(wr_en),   32'd1);
    check("t1_first_addr",  32'(wr_addr), 32'd0);
    check("t1_busy_during", 32'(busy),    32'd1);
    wait_idle("t1_idle");
    check_clear_all("t1");
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_busy",  32'(busy),     32'd0);

    // ---------------- T2: "AB" ----------------
    send(8'h41);
    check("t2_a_wr_en", 32'(wr_en),      32'd1);
    check("t2_a_addr",  32'(wr_addr),    32'd0);
    check("t2_a_data",  32'(wr_data),    32'h41);
    check("t2_a_col",   32'(cursor_col), 32'd1);
    send(8'h42);
    check("t2_b_addr",  32'(wr_addr),    32'd1);
    check("t2_b_data",  32'(wr_data),    32'h42);
    check("t2_b_col",   32'(cursor_col), 32'd2);
    @(negedge clk);
    check("t2_idle_wr_en", 32'(wr_en), 32'd0);

    // ---------------- T3: wrap at col 59 row 3 ----------------
    send(8'h0D);
    for (int i = 0; i < 3; i++) begin
      send(8'h0A);
      wait_idle("t3_lf_idle");
    end
    for (int i = 0; i < 59; i++) send(8'h2E);
    check("t3_pre_col", 32'(cursor_col), 32'd59);
    check("t3_pre_row", 32'(cursor_row), 32'd3);
    clear_log();
    send(8'h5A);
    check("t3_z_addr",  32'(wr_addr),  32'd239);
    check("t3_z_data",  32'(wr_data),  32'h5A);
    check("t3_z_busy",  32'(busy),     32'd1);
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t3_ready_low_cycles", 32'(n), 32'd60);
    wait_idle("t3_idle");
    check("t3_log_size", 32'(q_addr.size()), 32'd61);
    ok = (q_addr.size() == 61) ? 1 : 0;
    for (int i = 0; i < 60 && ok == 1; i++)
      if (q_addr[i + 1] !== 10'(240 + i) || q_data[i + 1] !== 8'h20) ok = 0;
    check("t3_row_clear_seq", 32'(ok), 32'd1);
    check("t3_col", 32'(cursor_col), 32'd0);
    check("t3_row", 32'(cursor_row), 32'd4);

    // ---------------- T4: LF on the last row, then CR ----------------
    send(8'h78);
    check("t4_x_addr", 32'(wr_addr), 32'd240);
    for (int i = 0; i < 12; i++) begin
      send(8'h0A);
      wait_idle("t4_lf_idle");
    end
    check("t4_pre_row", 32'(cursor_row), 32'd16);
    clear_log();
    send(8'h0A);
    check("t4_lf_first_addr", 32'(wr_addr),    32'd0);
    check("t4_lf_row",        32'(cursor_row), 32'd0);
    wait_idle("t4_idle");
    ok = (q_addr.size() == 60) ? 1 : 0;
    for (int i = 0; i < 60 && ok == 1; i++)
      if (q_addr[i] !== 10'(i) || q_data[i] !== 8'h20) ok = 0;
    check("t4_row0_clear", 32'(ok), 32'd1);
    check("t4_col_kept",   32'(cursor_col), 32'd1);
    send(8'h0D);
    check("t4_cr_wr_en", 32'(wr_en),      32'd0);
    check("t4_cr_col",   32'(cursor_col), 32'd0);

    // ---------------- T5: BS, ignored code, high bytes ----------------
    send(8'h68); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
    check("t5_col5", 32'(cursor_col), 32'd5);
    send(8'h08);
    check("t5_bs_wr_en", 32'(wr_en),      32'd1);
    check("t5_bs_addr",  32'(wr_addr),    32'd4);
    check("t5_bs_data",  32'(wr_data),    32'h20);
    check("t5_bs_col",   32'(cursor_col), 32'd4);
    send(8'h0D);
    send(8'h08);
    check("t5_bs0_wr_en", 32'(wr_en),      32'd0);
    check("t5_bs0_col",   32'(cursor_col), 32'd0);
    send(8'h01);
    check("t5_ign_wr_en", 32'(wr_en),      32'd0);
    check("t5_ign_col",   32'(cursor_col), 32'd0);
    check("t5_ign_row",   32'(cursor_row), 32'd0);
    send(8'h90);
    check("t5_90_addr", 32'(wr_addr),    32'd0);
    check("t5_90_data", 32'(wr_data),    32'h3F);
    check("t5_90_col",  32'(cursor_col), 32'd1);
    send(8'h7F);
    check("t5_7f_data", 32'(wr_data), 32'h3F);
    send(8'h7E);
    check("t5_7e_data", 32'(wr_data), 32'h7E);
    check("t5_7e_addr", 32'(wr_addr), 32'd2);

    // ---------------- T6: reset during FF clear ----------------
    clear_log();
    send(8'h0C);
    check("t6_ff_col",   32'(cursor_col), 32'd0);
    check("t6_ff_ready", 32'(in_ready),   32'd0);
    n = 0;
    while (wr_count < 300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_300", 32'(n < 2000), 32'd1);
    check("t6_mid_busy",    32'(busy),     32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_wr_en", 32'(wr_en),    32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    clear_log();
    m_clear_all();
    rst = 1'b0;
    wait_idle("t6_idle");
    check_clear_all("t6");
    check("t6_col", 32'(cursor_col), 32'd0);
    check("t6_row", 32'(cursor_row), 32'd0);

    // ---------------- mixed stream vs reference console ----------------
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 31);
      if (i == 300)      b = 8'h0C;
      else if (r == 0)   b = 8'h0A;
      else if (r == 1)   b = 8'h0D;
      else if (r == 2)   b = 8'h08;
      else if (r == 3)   b = 8'h01;
      else if (r == 4)   b = 8'(8'h80 + $urandom_range(0, 127));
      else               b = 8'($urandom_range(32, 126));
      send(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("rand_idle");
    mism = 0;
    for (int i = 0; i < 1020; i++)
      if (dut_ram[i] !== exp_ram[i]) mism++;
    check("rand_ram_mismatches", 32'(mism), 32'd0);
    check("rand_col", 32'(cursor_col), 32'(m_col));
    check("rand_row", 32'(cursor_row), 32'(m_row));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
